// File: rtl/des_stream_ctrl.sv
// Request FIFO and sequencer for an iterative DES core: queues blocks, drives
// the core one block at a time, watches for a hung core and returns results.
module des_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [55:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [63:0] core_desIn,
  output logic [55:0] core_key,
  output logic        core_decrypt,
  output logic        core_init,
  input  logic        core_finish,
  input  logic [63:0] core_desOut,
  output logic        err_timeout,
  input  logic        err_clr,
  output logic [15:0] blocks_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 2);

  typedef struct packed {
    logic        decrypt;
    logic [55:0] key;
    logic [63:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_t;

  state_t          state;
  req_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, next_count;
  logic [WW-1:0]   wd;
  logic            push, pop, timeout_hit;

  assign push        = in_valid && in_ready;
  assign pop         = (state == IDLE) && (count != '0);
  // The watchdog has already counted TIMEOUT-2 idle BUSY cycles; this one completes the budget.
  assign timeout_hit = (state == BUSY) && !core_finish && (wd == WD_LAST);

  // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
  always_comb begin
    next_count = count;
    case ({push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // NOTE: FIFO storage is deliberately not reset; only pointers and count are, and empty entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{decrypt: in_decrypt, key: in_key, data: in_data};
  end

  // NOTE: all sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b0;
      wd           <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      core_desIn   <= '0;
      core_key     <= '0;
      core_decrypt <= 1'b0;
      core_init    <= 1'b0;
      err_timeout  <= 1'b0;
      blocks_done  <= '0;
    end else begin
      count     <= next_count;
      in_ready  <= (next_count != FULL);
      core_init <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            core_desIn   <= mem[rd_ptr].data;
            core_key     <= mem[rd_ptr].key;
            core_decrypt <= mem[rd_ptr].decrypt;
            rd_ptr       <= rd_ptr + 1'b1;
            state        <= START;
          end
        end
        START: begin
          wd    <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (core_finish) begin
            out_data    <= core_desOut;
            out_valid   <= 1'b1;
            blocks_done <= blocks_done + 16'd1;
            state       <= HOLD;
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Directed bench for des_stream_ctrl with a behavioural DES core stub
// (finish 17 cycles after init, desOut = desIn ^ {8'h00, key}).
module tb_des_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [55:0] in_key;
  logic        in_decrypt;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [63:0] core_desIn;
  logic [55:0] core_key;
  logic        core_decrypt, core_init;
  logic        core_finish = 1'b0;
  logic [63:0] core_desOut = '0;
  logic        err_timeout, err_clr;
  logic [15:0] blocks_done;

  int total = 0;
  int bad   = 0;
  int init_cnt = 0;

  des_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(24)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_desIn(core_desIn), .core_key(core_key), .core_decrypt(core_decrypt),
    .core_init(core_init), .core_finish(core_finish), .core_desOut(core_desOut),
    .err_timeout(err_timeout), .err_clr(err_clr), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  // Core stub; stub_en=0 makes it swallow the block and never finish.
  logic        stub_en = 1'b1;
  logic        sbusy   = 1'b0;
  logic [4:0]  scnt    = '0;
  logic [63:0] slatch  = '0;
  always @(posedge clk) begin
    core_finish <= 1'b0;
    if (core_init) begin
      init_cnt <= init_cnt + 1;
      sbusy    <= 1'b1;
      scnt     <= 5'd1;
      slatch   <= core_desIn ^ {8'h00, core_key};
    end else if (sbusy) begin
      scnt <= scnt + 5'd1;
      if (scnt == 5'd16) begin
        sbusy <= 1'b0;
        if (stub_en) begin
          core_finish <= 1'b1;
          core_desOut <= slatch;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; drop in_valid if the request was taken on the rising edge.
  task automatic step();
    bit acc;
    acc = in_valid && in_ready;
    @(negedge clk);
    if (acc) in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [55:0] k, input logic dec);
    bit to;
    to = 1'b1;
    in_data = d; in_key = k; in_decrypt = dec; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!in_valid) begin to = 1'b0; break; end
    end
    in_valid = 1'b0;
    check("send_accepted_tmo", to, 1'b0);
  endtask

  task automatic wait_init();
    bit to;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (core_init) begin to = 1'b0; break; end
      step();
    end
    check("wait_init_tmo", to, 1'b0);
  endtask

  task automatic wait_out(output logic [63:0] d);
    bit to;
    to = 1'b1;
    d  = '0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin to = 1'b0; d = out_data; break; end
      step();
    end
    check("wait_out_tmo", to, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] bp_d [6];
    logic [55:0] bp_k [6];
    bit          flag;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ctrl_bits", {out_valid, core_init, core_decrypt, err_timeout}, 4'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_core_bus", {core_desIn, core_key}, 120'h0);
    check("rst_blocks_done", blocks_done, 16'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    check("rel_in_ready_before_edge", in_ready, 1'b0);
    step();
    check("rel_in_ready_after_edge", in_ready, 1'b1);

    // Single block with latency checks
    in_data = 64'h0123456789ABCDEF; in_key = 56'h0; in_decrypt = 1'b0; in_valid = 1'b1;
    step();
    check("single_accepted", in_valid, 1'b0);
    check("lat_init_n1", core_init, 1'b0);
    step();
    check("lat_init_n2", core_init, 1'b1);
    check("start_desin", core_desIn, 64'h0123456789ABCDEF);
    step();
    check("init_one_cycle", core_init, 1'b0);
    flag = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (core_finish) begin flag = 1'b0; break; end
      step();
    end
    check("finish_seen_tmo", flag, 1'b0);
    check("no_valid_at_finish", out_valid, 1'b0);
    step();
    check("valid_after_finish", out_valid, 1'b1);
    check("single_out_data", out_data, 64'h0123456789ABCDEF);
    check("single_blocks_done", blocks_done, 16'd1);
    step();
    check("valid_clears_on_ready", out_valid, 1'b0);
    check("single_init_pulses", init_cnt, 1);

    // Back-pressure: 6 back-to-back requests with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_d[i] = {16'hC0DE, 16'(i), 32'h600DF00D};
      bp_k[i] = {48'h0123456789AB, 8'(i * 17)};
    end
    for (int i = 0; i < 5; i++) send(bp_d[i], bp_k[i], 1'b0);
    in_data = bp_d[5]; in_key = bp_k[5]; in_decrypt = 1'b0; in_valid = 1'b1;
    check("bp_full_after_5", in_ready, 1'b0);
    for (int i = 0; i < 25; i++) step();
    check("bp_still_full", {in_ready, in_valid}, 2'b01);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_data", out_data, bp_d[0] ^ {8'h00, bp_k[0]});
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_out(got);
      check($sformatf("bp_result_%0d", i), got, bp_d[i] ^ {8'h00, bp_k[i]});
    end
    check("bp_blocks_done", blocks_done, 16'd7);

    // Watchdog timeout, with err_clr on the same cycle as the timeout
    stub_en = 1'b0;
    send(64'hFEEDFACECAFEBEEF, 56'h11223344556677, 1'b1);
    wait_init();
    flag = 1'b0;
    for (int i = 0; i < 23; i++) begin
      step();
      flag |= out_valid;
    end
    check("tmo_not_early", err_timeout, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_set_beats_clr", err_timeout, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      flag |= out_valid;
    end
    check("tmo_sticky", err_timeout, 1'b1);
    check("tmo_no_out_valid", flag, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_cleared", err_timeout, 1'b0);
    stub_en = 1'b1;
    send(64'h0F1E2D3C4B5A6978, 56'h00000000000001, 1'b0);
    wait_out(got);
    check("post_tmo_data", got, 64'h0F1E2D3C4B5A6979);
    check("post_tmo_blocks_done", blocks_done, 16'd8);

    // Key stability while the core is busy
    send(64'h0000000000000000, 56'h54726F6A616E41, 1'b1);
    in_key = 56'hFFFFFFFFFFFFFF;
    wait_init();
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (core_key !== 56'h54726F6A616E41 || core_decrypt !== 1'b1) flag = 1'b1;
      if (core_finish) break;
      step();
    end
    check("stable_key_decrypt", flag, 1'b0);
    wait_out(got);
    check("stable_out_data", got, 64'h0054726F6A616E41);

    // Asynchronous reset in the middle of BUSY
    send(64'hA5A5A5A5A5A5A5A5, 56'h5A5A5A5A5A5A5A, 1'b1);
    wait_init();
    for (int i = 0; i < 8; i++) step();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ctrl_bits", {out_valid, core_init, core_decrypt, err_timeout, in_ready}, 5'b0);
    check("mid_rst_out_data", out_data, 64'h0);
    check("mid_rst_core_bus", {core_desIn, core_key}, 120'h0);
    check("mid_rst_blocks_done", blocks_done, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("mid_rst_ready_back", in_ready, 1'b1);
    flag = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      flag |= out_valid;
    end
    check("late_finish_ignored", {flag, blocks_done}, 17'h0);

    // blocks_done wrap
    force dut.blocks_done = 16'hFFFE;
    #1 release dut.blocks_done;
    send(64'h1, 56'h0, 1'b0);
    wait_out(got);
    check("wrap_ffff", blocks_done, 16'hFFFF);
    send(64'h2, 56'h0, 1'b0);
    wait_out(got);
    check("wrap_zero", blocks_done, 16'h0000);
    check("wrap_data", got, 64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_stream_ctrl.md
DES_STREAM_CTRL -- requirements
Module: des_stream_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 4, number of queued input requests (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, 24, maximum cycles allowed from core_init to core_finish.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  upstream request handshake.
REQ-006 SHALL have ports in_data input 64, in_key input 56, in_decrypt input 1  request payload.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_data output 64  result handshake.
REQ-008 SHALL have ports core_desIn output 64, core_key output 56, core_decrypt output 1, core_init output 1  drive to DES core.
REQ-009 SHALL have ports core_finish input 1, core_desOut input 64  result from DES core.
REQ-010 SHALL have ports err_timeout output 1 (sticky), err_clr input 1, blocks_done output 16.

Function
REQ-011 SHALL buffer requests in a FIFO of FIFO_DEPTH entries of {decrypt, key, data}; in_ready = FIFO not full (registered count).
REQ-012 SHALL push when in_valid && in_ready; in_valid while full is not accepted and payload is not captured.
REQ-013 SHALL support push and pop in the same cycle when not full; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, BUSY, HOLD.
REQ-015 IDLE: if FIFO non-empty, pop head into work registers, next state START; else stay IDLE.
REQ-016 START: core_init=1 for exactly this one cycle; watchdog counter cleared; next state BUSY.
REQ-017 core_desIn/core_key/core_decrypt SHALL equal work registers and stay stable from START until leaving BUSY.
REQ-018 BUSY: core_finish=1 -> capture core_desOut into out_data, set out_valid, increment blocks_done (wraps 16'hFFFF->0), next state HOLD.
REQ-019 BUSY: core_finish=0 -> increment watchdog; when watchdog reaches TIMEOUT-1 set err_timeout, discard block, out_valid stays 0, next state IDLE.
REQ-020 core_finish in IDLE, START or HOLD SHALL be ignored.
REQ-021 HOLD: out_valid and out_data SHALL remain stable until out_ready=1; on that cycle out_valid clears, next state IDLE.
REQ-022 Minimum latency: request accepted at cycle N, core_init at N+2, out_valid one cycle after core_finish.
REQ-023 err_timeout SHALL stay set until err_clr=1; err_clr and a new timeout in the same cycle -> err_timeout remains 1.
REQ-024 core_init SHALL never assert while state is BUSY or HOLD.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, FIFO empty, in_ready=0 during reset then 1 the first cycle after release.
REQ-026 Under reset: out_valid=0, out_data=0, core_init=0, core_desIn=0, core_key=0, core_decrypt=0, err_timeout=0, blocks_done=0.
REQ-027 Reset mid-BUSY SHALL abandon the block without producing out_valid; a core_finish after release is ignored.

Verification (core stub: finish 17 cycles after init, desOut = desIn ^ {8'h00, key})
REQ-028 Single block: data 64'h0123456789ABCDEF, key 56'h0, out_ready=1 -> one core_init pulse, out_data 64'h0123456789ABCDEF, blocks_done=1.
REQ-029 Back-pressure: 6 requests back-to-back, out_ready=0 -> in_ready drops after 4 accepted plus 1 in work registers; releasing out_ready yields all 6 results in order.
REQ-030 Timeout: stub never asserts finish -> err_timeout=1 at cycle TIMEOUT after START, no out_valid; err_clr=1 clears it; next block completes normally.
REQ-031 Stability: in_key changes while BUSY -> core_key holds accepted value 56'h54726F6A616E41 until finish.
REQ-032 Reset mid-operation: reset=0 at cycle 8 of BUSY -> all outputs 0 asynchronously; late finish produces no out_valid.
REQ-033 Counter wrap: preload via 65536 blocks (or force) -> blocks_done rolls 16'hFFFF to 16'h0000.
